// File: rtl/tawas_pkg.sv
// Shared types and helpers for the Tawas per-slice register file.
package tawas_pkg;

  localparam int unsigned NUM_SLICES = 4;
  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned DATA_W     = 32;

  typedef logic [1:0]        slice_t;
  typedef logic [2:0]        reg_sel_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Writeback bank for a given issue slice; wraps modulo NUM_SLICES.
  function automatic slice_t wb_bank(input slice_t s, input int unsigned ofs);
    return s + slice_t'(ofs);
  endfunction

endpackage

// File: rtl/tawas_regfile_bank.sv
// One thread slice's register bank: AU-priority dual write, three combinational reads.
module tawas_regfile_bank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              au_we,
  input  logic [SEL_W-1:0]  au_sel,
  input  logic [DATA_W-1:0] au_data,
  input  logic              ls_we,
  input  logic [SEL_W-1:0]  ls_sel,
  input  logic [DATA_W-1:0] ls_data,
  input  logic [SEL_W-1:0]  rd_sel_a,
  input  logic [SEL_W-1:0]  rd_sel_b,
  input  logic [SEL_W-1:0]  rd_sel_c,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] rd_c
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Selects beyond NUM_REGS never match an index, so such writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (au_we && (au_sel == SEL_W'(i)))      r_regs[i] <= au_data;
        else if (ls_we && (ls_sel == SEL_W'(i))) r_regs[i] <= ls_data;
      end
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    rd_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_a == SEL_W'(i)) rd_a = r_regs[i];
      if (rd_sel_b == SEL_W'(i)) rd_b = r_regs[i];
      if (rd_sel_c == SEL_W'(i)) rd_c = r_regs[i];
    end
  end

endmodule

// File: rtl/tawas_regfile.sv
// Tawas general register file: 4 slice banks, bank select, write->read bypass, conflict counter.
module tawas_regfile #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned AU_WB_OFS = 1,
  parameter int unsigned LS_WB_OFS = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        slice,
  input  logic [2:0]        au_ra_sel,
  output logic [DATA_W-1:0] au_ra,
  input  logic [2:0]        au_rb_sel,
  output logic [DATA_W-1:0] au_rb,
  input  logic              au_rc_vld,
  input  logic [2:0]        au_rc_sel,
  input  logic [DATA_W-1:0] au_rc,
  input  logic [2:0]        ls_rd_sel,
  output logic [DATA_W-1:0] ls_rd,
  input  logic              ls_wr_vld,
  input  logic [2:0]        ls_wr_sel,
  input  logic [DATA_W-1:0] ls_wr,
  output logic              wr_conflict,
  output logic [CNT_W-1:0]  conflict_cnt
);
  import tawas_pkg::*;

  localparam int unsigned SEL_W = 3;

  slice_t            w_au_bank;
  slice_t            w_ls_bank;
  logic              w_au_in_range;
  logic              w_ls_in_range;
  logic              w_au_live;
  logic              w_ls_live;
  logic              w_conflict;
  logic [DATA_W-1:0] w_bank_ra [NUM_SLICES];
  logic [DATA_W-1:0] w_bank_rb [NUM_SLICES];
  logic [DATA_W-1:0] w_bank_ls [NUM_SLICES];
  logic              r_wr_conflict;
  logic [CNT_W-1:0]  r_conflict_cnt;

  assign w_au_bank     = wb_bank(slice, AU_WB_OFS);
  assign w_ls_bank     = wb_bank(slice, LS_WB_OFS);
  assign w_au_in_range = 32'(au_rc_sel) < NUM_REGS;
  assign w_ls_in_range = 32'(ls_wr_sel) < NUM_REGS;

  for (genvar b = 0; b < NUM_SLICES; b++) begin : g_bank
    tawas_regfile_bank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .au_we    (au_rc_vld && (w_au_bank == slice_t'(b))),
      .au_sel   (au_rc_sel),
      .au_data  (au_rc),
      .ls_we    (ls_wr_vld && (w_ls_bank == slice_t'(b))),
      .ls_sel   (ls_wr_sel),
      .ls_data  (ls_wr),
      .rd_sel_a (au_ra_sel),
      .rd_sel_b (au_rb_sel),
      .rd_sel_c (ls_rd_sel),
      .rd_a     (w_bank_ra[b]),
      .rd_b     (w_bank_rb[b]),
      .rd_c     (w_bank_ls[b])
    );
  end

  // Bypass only fires when a write targets the bank being read; gated by
  // rst_n because reset discards that write and reads must show 0.
  assign w_au_live = rst_n && au_rc_vld && w_au_in_range && (w_au_bank == slice);
  assign w_ls_live = rst_n && ls_wr_vld && w_ls_in_range && (w_ls_bank == slice);

  function automatic logic [DATA_W-1:0] bypass(
    input logic [SEL_W-1:0]  rd_sel,
    input logic [DATA_W-1:0] stored,
    input logic              au_live,
    input logic [SEL_W-1:0]  au_sel,
    input logic [DATA_W-1:0] au_d,
    input logic              ls_live,
    input logic [SEL_W-1:0]  ls_sel,
    input logic [DATA_W-1:0] ls_d
  );
    if (au_live && (au_sel == rd_sel))      return au_d;
    else if (ls_live && (ls_sel == rd_sel)) return ls_d;
    else                                    return stored;
  endfunction

  assign au_ra = bypass(au_ra_sel, w_bank_ra[slice], w_au_live, au_rc_sel, au_rc,
                        w_ls_live, ls_wr_sel, ls_wr);
  assign au_rb = bypass(au_rb_sel, w_bank_rb[slice], w_au_live, au_rc_sel, au_rc,
                        w_ls_live, ls_wr_sel, ls_wr);
  assign ls_rd = bypass(ls_rd_sel, w_bank_ls[slice], w_au_live, au_rc_sel, au_rc,
                        w_ls_live, ls_wr_sel, ls_wr);

  assign w_conflict = au_rc_vld && ls_wr_vld && w_au_in_range &&
                      (w_au_bank == w_ls_bank) && (au_rc_sel == ls_wr_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_conflict  <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      r_wr_conflict <= w_conflict;
      if (w_conflict && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign wr_conflict  = r_wr_conflict;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_tawas_regfile.sv
// Scoreboard bench: three shared-stimulus builds (default, LS_WB_OFS=1, AU_WB_OFS=0).
module tb_tawas_regfile;

  localparam int P_RA  = 0;
  localparam int P_RB  = 1;
  localparam int P_LS  = 2;
  localparam int P_CF  = 3;
  localparam int P_CNT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  slice;
  logic [2:0]  au_ra_sel, au_rb_sel, au_rc_sel, ls_rd_sel, ls_wr_sel;
  logic        au_rc_vld, ls_wr_vld;
  logic [31:0] au_rc, ls_wr;

  logic [31:0] ra  [3];
  logic [31:0] rb  [3];
  logic [31:0] lsr [3];
  logic        cf  [3];
  logic [15:0] cnt [3];

  typedef struct {
    string       name;
    int          d;
    int          p;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tawas_regfile #(.AU_WB_OFS(1), .LS_WB_OFS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .slice(slice),
    .au_ra_sel(au_ra_sel), .au_ra(ra[0]), .au_rb_sel(au_rb_sel), .au_rb(rb[0]),
    .au_rc_vld(au_rc_vld), .au_rc_sel(au_rc_sel), .au_rc(au_rc),
    .ls_rd_sel(ls_rd_sel), .ls_rd(lsr[0]),
    .ls_wr_vld(ls_wr_vld), .ls_wr_sel(ls_wr_sel), .ls_wr(ls_wr),
    .wr_conflict(cf[0]), .conflict_cnt(cnt[0])
  );

  tawas_regfile #(.AU_WB_OFS(1), .LS_WB_OFS(1)) u_cf (
    .clk(clk), .rst_n(rst_n), .slice(slice),
    .au_ra_sel(au_ra_sel), .au_ra(ra[1]), .au_rb_sel(au_rb_sel), .au_rb(rb[1]),
    .au_rc_vld(au_rc_vld), .au_rc_sel(au_rc_sel), .au_rc(au_rc),
    .ls_rd_sel(ls_rd_sel), .ls_rd(lsr[1]),
    .ls_wr_vld(ls_wr_vld), .ls_wr_sel(ls_wr_sel), .ls_wr(ls_wr),
    .wr_conflict(cf[1]), .conflict_cnt(cnt[1])
  );

  tawas_regfile #(.AU_WB_OFS(0), .LS_WB_OFS(2)) u_bp (
    .clk(clk), .rst_n(rst_n), .slice(slice),
    .au_ra_sel(au_ra_sel), .au_ra(ra[2]), .au_rb_sel(au_rb_sel), .au_rb(rb[2]),
    .au_rc_vld(au_rc_vld), .au_rc_sel(au_rc_sel), .au_rc(au_rc),
    .ls_rd_sel(ls_rd_sel), .ls_rd(lsr[2]),
    .ls_wr_vld(ls_wr_vld), .ls_wr_sel(ls_wr_sel), .ls_wr(ls_wr),
    .wr_conflict(cf[2]), .conflict_cnt(cnt[2])
  );

  function automatic logic [31:0] probe(input int d, input int p);
    case (p)
      P_RA:    return ra[d];
      P_RB:    return rb[d];
      P_LS:    return lsr[d];
      P_CF:    return {31'b0, cf[d]};
      default: return {16'b0, cnt[d]};
    endcase
  endfunction

  task automatic expect_out(input string n, input int d, input int p, input logic [31:0] v);
    exp_t e;
    e.name = n; e.d = d; e.p = p; e.v = v;
    sb.push_back(e);
  endtask

  task automatic check_now(input string n, input int d, input int p, input logic [31:0] v);
    logic [31:0] a;
    a = probe(d, p);
    n_cmp++;
    if (a !== v) begin
      n_err++;
      $display("FAIL %s (dut %0d port %0d, immediate): got %h, expected %h", n, d, p, a, v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    au_rc_vld = 1'b0;
    ls_wr_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = probe(e.d, e.p);
      n_cmp++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s (dut %0d port %0d): got %h, expected %h", e.name, e.d, e.p, a, e.v);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the expected time");
    $display("*** SUMMARY: %0d compared / %0d mismatched (timeout) ***", n_cmp, n_err + 1);
    $finish;
  end

  initial begin
    rst_n = 1'b0; slice = '0;
    au_ra_sel = '0; au_rb_sel = '0; au_rc_sel = '0; ls_rd_sel = '0; ls_wr_sel = '0;
    au_rc_vld = 1'b0; ls_wr_vld = 1'b0; au_rc = '0; ls_wr = '0;
    tick();

    for (int i = 0; i < 3; i++) begin
      slice = 2'(i); au_ra_sel = 3'(i + 1);
      expect_out("rst_ra", 0, P_RA, 32'h0);
      expect_out("rst_cnt", i, P_CNT, 32'h0);
      expect_out("rst_cf", i, P_CF, 32'h0);
      #1;
      check_now("rst_now_ra", i, P_RA, 32'h0);
      check_now("rst_now_cnt", i, P_CNT, 32'h0);
      tick();
    end
    rst_n = 1'b1;
    #1;
    check_now("rst_release_cnt", 0, P_CNT, 32'h0);
    check_now("rst_release_cf", 0, P_CF, 32'h0);

    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 8; r++) begin
        slice = 2'(s); au_ra_sel = 3'(r); au_rb_sel = 3'(7 - r); ls_rd_sel = 3'(r);
        expect_out("init_ra", 0, P_RA, 32'h0);
        expect_out("init_rb", 0, P_RB, 32'h0);
        expect_out("init_ls", 0, P_LS, 32'h0);
        tick();
      end
    end
    expect_out("init_cnt", 0, P_CNT, 32'h0);

    slice = 2'd3; au_rc_vld = 1'b1; au_rc_sel = 3'd5; au_rc = 32'hDEADBEEF; au_ra_sel = 3'd5;
    expect_out("wrap_same_cycle_b3", 0, P_RA, 32'h0);
    expect_out("wrap_bypass_ofs0", 2, P_RA, 32'hDEADBEEF);
    tick();
    idle();
    for (int s = 0; s < 4; s++) begin
      slice = 2'(s); au_ra_sel = 3'd5;
      expect_out("wrap_read", 0, P_RA, (s == 0) ? 32'hDEADBEEF : 32'h0);
      tick();
    end

    slice = 2'd0;
    au_rc_vld = 1'b1; au_rc_sel = 3'd2; au_rc = 32'h11;
    ls_wr_vld = 1'b1; ls_wr_sel = 3'd2; ls_wr = 32'h22;
    tick();
    idle();
    slice = 2'd1; au_ra_sel = 3'd2;
    expect_out("par_b1r2", 0, P_RA, 32'h11);
    expect_out("par_no_conflict", 0, P_CF, 32'h0);
    tick();
    slice = 2'd2; ls_rd_sel = 3'd2; au_rb_sel = 3'd2;
    expect_out("par_b2r2_ls", 0, P_LS, 32'h22);
    expect_out("par_b2r2_rb", 0, P_RB, 32'h22);
    tick();
    slice = 2'd3;
    expect_out("par_b3r2", 0, P_LS, 32'h0);
    tick();

    rst_n = 1'b0; slice = 2'd1; au_ra_sel = 3'd2;
    expect_out("rerst_reg", 0, P_RA, 32'h0);
    expect_out("rerst_cnt", 1, P_CNT, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    slice = 2'd0;
    au_rc_vld = 1'b1; au_rc_sel = 3'd4; au_rc = 32'hAAAA0000;
    ls_wr_vld = 1'b1; ls_wr_sel = 3'd4; ls_wr = 32'h00005555;
    expect_out("cf_before", 1, P_CF, 32'h0);
    tick();
    idle();
    slice = 2'd1; au_ra_sel = 3'd4;
    expect_out("cf_au_wins", 1, P_RA, 32'hAAAA0000);
    expect_out("cf_pulse", 1, P_CF, 32'h1);
    expect_out("cf_cnt1", 1, P_CNT, 32'h1);
    expect_out("cf_default_none", 0, P_CF, 32'h0);
    tick();
    slice = 2'd2; ls_rd_sel = 3'd4;
    expect_out("cf_pulse_end", 1, P_CF, 32'h0);
    expect_out("cf_cnt_hold", 1, P_CNT, 32'h1);
    expect_out("cf_default_ls", 0, P_LS, 32'h00005555);
    tick();

    slice = 2'd0; au_rc_vld = 1'b1; ls_wr_vld = 1'b1;
    for (int i = 0; i < 65538; i++) begin
      if (i == 1)     expect_out("sat_cf", 1, P_CF, 32'h1);
      if (i == 65533) expect_out("sat_cnt_fffe", 1, P_CNT, 32'hFFFE);
      if (i == 65534) expect_out("sat_cnt_ffff", 1, P_CNT, 32'hFFFF);
      if (i == 65537) expect_out("sat_cnt_hold", 1, P_CNT, 32'hFFFF);
      tick();
    end
    idle();
    slice = 2'd1;
    expect_out("sat_final", 1, P_CNT, 32'hFFFF);
    expect_out("sat_last_cf", 1, P_CF, 32'h1);
    tick();
    expect_out("sat_cf_clear", 1, P_CF, 32'h0);
    expect_out("sat_final2", 1, P_CNT, 32'hFFFF);
    tick();

    slice = 2'd2; au_rc_vld = 1'b1; au_rc_sel = 3'd7; au_rc = 32'h12345678; au_rb_sel = 3'd7;
    expect_out("byp_same_cycle", 2, P_RB, 32'h12345678);
    expect_out("byp_default_none", 0, P_RB, 32'h0);
    tick();
    idle();
    expect_out("byp_stored", 2, P_RB, 32'h12345678);
    tick();

    slice = 2'd1; au_rc_vld = 1'b1; au_rc_sel = 3'd3; au_rc = 32'hCAFEF00D; au_ra_sel = 3'd3;
    expect_out("mid_rst_read", 2, P_RA, 32'h0);
    expect_out("mid_rst_cnt", 1, P_CNT, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check_now("mid_rst_immediate_ra", 2, P_RA, 32'h0);
    check_now("mid_rst_immediate_cnt", 1, P_CNT, 32'h0);
    tick();
    rst_n = 1'b1;
    idle();
    expect_out("mid_rst_not_written", 2, P_RA, 32'h0);
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    if (n_err != 0) $display("FAIL: %0d mismatches", n_err);
    else            $display("PASS");
    $finish;
  end

endmodule
